// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned COL_W  = 32;

  // InvMixColumns circulant coefficients, row 0 of the inverse matrix
  localparam logic [BYTE_W-1:0] INV_MC_C0 = 8'h0E;
  localparam logic [BYTE_W-1:0] INV_MC_C1 = 8'h0B;
  localparam logic [BYTE_W-1:0] INV_MC_C2 = 8'h0D;
  localparam logic [BYTE_W-1:0] INV_MC_C3 = 8'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x modulo the AES polynomial 0x11B
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mul_lut.sv
// Registered multiply-by-constant lookup in GF(2^8); output is zero when not enabled.
module gf_mul_lut
  import aes_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COEF = 8'h01
) (
  input  logic              CLK,
  input  logic              Read_Enable,
  input  logic [BYTE_W-1:0] Read_Address,
  output logic [BYTE_W-1:0] Read_Data
);

  // Shift-and-add product built from xtime, so no per-constant table is stored
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] c);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] m;
    p = '0;
    m = a;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (c[i]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

  logic [BYTE_W-1:0] product;

  // Combinational product of the address and the fixed coefficient
  always_comb begin
    product = gf_mul(Read_Address, COEF);
  end

  // One-cycle registered read, forced to zero when disabled
  always_ff @(posedge CLK) begin
    Read_Data <= Read_Enable ? product : '0;
  end

endmodule

// File: rtl/inv_mix_column_engine.sv
// Sequential InvMixColumns for one column: one input byte per cycle through
// four constant-multiplier lookups, accumulated into four output bytes.
module inv_mix_column_engine
  import aes_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [COL_W-1:0] In_Column,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [COL_W-1:0] Out_Column,
  output logic             Busy
);

  localparam int unsigned NUM_BYTES = 4;
  localparam int unsigned CNT_W     = 3;

  state_t                           state;
  logic [CNT_W-1:0]                 cnt;
  logic [COL_W-1:0]                 col_q;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] acc;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] acc_nxt;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] prod;
  logic                             rd_en;
  logic [BYTE_W-1:0]                rd_addr;
  logic [1:0]                       j_idx;

  // Lookup address: byte a_cnt of the latched column, row 0 in the top byte
  always_comb begin
    rd_en   = (state == RUN) && (cnt < CNT_W'(NUM_BYTES));
    rd_addr = '0;
    case (cnt[1:0])
      2'd0:    rd_addr = col_q[31:24];
      2'd1:    rd_addr = col_q[23:16];
      2'd2:    rd_addr = col_q[15:8];
      default: rd_addr = col_q[7:0];
    endcase
  end

  // Accumulator i takes the product of byte j with coefficient C[(j-i) mod 4]
  always_comb begin
    j_idx   = 2'(cnt - CNT_W'(1));
    acc_nxt = acc;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      acc_nxt[NUM_BYTES-1-i] = acc[NUM_BYTES-1-i] ^ prod[2'(j_idx - 2'(i))];
    end
  end

  // prod[k] holds the product with coefficient C[k]
  gf_mul_lut #(.COEF(INV_MC_C0)) u_mul_c0 (
    .CLK(CLK), .Read_Enable(rd_en), .Read_Address(rd_addr), .Read_Data(prod[0])
  );
  gf_mul_lut #(.COEF(INV_MC_C1)) u_mul_c1 (
    .CLK(CLK), .Read_Enable(rd_en), .Read_Address(rd_addr), .Read_Data(prod[1])
  );
  gf_mul_lut #(.COEF(INV_MC_C2)) u_mul_c2 (
    .CLK(CLK), .Read_Enable(rd_en), .Read_Address(rd_addr), .Read_Data(prod[2])
  );
  gf_mul_lut #(.COEF(INV_MC_C3)) u_mul_c3 (
    .CLK(CLK), .Read_Enable(rd_en), .Read_Address(rd_addr), .Read_Data(prod[3])
  );

  // Control FSM with registered handshake outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      col_q      <= '0;
      acc        <= '0;
      In_Ready   <= 1'b0;
      Out_Valid  <= 1'b0;
      Out_Column <= '0;
      Busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid && In_Ready) begin
            col_q    <= In_Column;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            In_Ready <= 1'b0;
            Busy     <= 1'b1;
          end else begin
            In_Ready <= 1'b1;
          end
        end
        RUN: begin
          // Lookup data for byte cnt-1 is valid while cnt is 1..4
          if (cnt != '0) acc <= acc_nxt;
          if (cnt == CNT_W'(NUM_BYTES)) begin
            cnt        <= '0;
            state      <= DONE;
            Out_Valid  <= 1'b1;
            Out_Column <= acc_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (Out_Ready) begin
            state     <= IDLE;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
            In_Ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_column_engine.sv
// Directed bench for inv_mix_column_engine using known InvMixColumns vectors.
module tb_inv_mix_column_engine;

  logic        CLK;
  logic        RST_N;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Column;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Column;
  logic        Busy;

  int n_tests;
  int n_fail;

  inv_mix_column_engine dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .In_Column(In_Column),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Out_Column(Out_Column),
    .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case a wait escapes its bound
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one column, check latency, optional back-pressure and stray In_Valid
  task automatic run_column(input string tag, input logic [31:0] col,
                            input logic [31:0] exp, input int hold, input bit pulse);
    for (int k = 0; k < 20 && In_Ready !== 1'b1; k++) @(negedge CLK);
    check({tag, " ready_before"}, 32'(In_Ready), 32'd1);
    In_Valid  = 1'b1;
    In_Column = col;
    @(negedge CLK);
    In_Valid  = 1'b0;
    check({tag, " ready_after_accept"}, 32'(In_Ready), 32'd0);
    check({tag, " busy_after_accept"}, 32'(Busy), 32'd1);
    if (pulse) begin
      In_Valid  = 1'b1;
      In_Column = 32'hFFFFFFFF;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      In_Valid = 1'b0;
      check({tag, " valid_early"}, 32'(Out_Valid), 32'd0);
    end
    @(negedge CLK);
    check({tag, " valid_at_5"}, 32'(Out_Valid), 32'd1);
    check({tag, " column"}, Out_Column, exp);
    check({tag, " ready_in_done"}, 32'(In_Ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      check({tag, " hold_column"}, Out_Column, exp);
      check({tag, " hold_valid"}, 32'(Out_Valid), 32'd1);
      check({tag, " hold_ready"}, 32'(In_Ready), 32'd0);
    end
    Out_Ready = 1'b1;
    @(negedge CLK);
    Out_Ready = 1'b0;
    check({tag, " valid_after_hs"}, 32'(Out_Valid), 32'd0);
    check({tag, " ready_after_hs"}, 32'(In_Ready), 32'd1);
    check({tag, " busy_after_hs"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    RST_N     = 1'b0;
    In_Valid  = 1'b0;
    In_Column = '0;
    Out_Ready = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_in_ready", 32'(In_Ready), 32'd0);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_out_column", Out_Column, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rst_release_ready", 32'(In_Ready), 32'd1);

    // Known-answer columns
    run_column("kat0", 32'h8E4DA1BC, 32'hDB135345, 0, 1'b0);
    run_column("kat1", 32'h9FDC589D, 32'hF20A225C, 0, 1'b0);
    run_column("kat2", 32'hD5D5D7D6, 32'hD4D4D4D5, 0, 1'b0);
    run_column("kat3", 32'h01010101, 32'h01010101, 0, 1'b0);
    run_column("kat4", 32'hC6C6C6C6, 32'hC6C6C6C6, 0, 1'b0);
    run_column("kat5", 32'h00000000, 32'h00000000, 0, 1'b0);

    // Back-pressure with a stray In_Valid during RUN
    run_column("bp", 32'h9FDC589D, 32'hF20A225C, 10, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("bp_no_second_output", 32'(Out_Valid), 32'd0);
    end

    // Reset mid-RUN at cnt=2
    for (int k = 0; k < 20 && In_Ready !== 1'b1; k++) @(negedge CLK);
    In_Valid  = 1'b1;
    In_Column = 32'h9FDC589D;
    @(negedge CLK);
    In_Valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("midrst_in_ready", 32'(In_Ready), 32'd0);
    check("midrst_out_valid", 32'(Out_Valid), 32'd0);
    check("midrst_out_column", Out_Column, 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    @(negedge CLK);
    check("midrst_ready_next", 32'(In_Ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("midrst_no_output", 32'(Out_Valid), 32'd0);
    end
    run_column("post_rst", 32'h8E4DA1BC, 32'hDB135345, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
